regf_mp: RTL and testbench

- Parametrised successor of the CPU register file: configurable data width, register count and read-port count.
- Two write ports, optional hardwired-zero register 0, and optional write-to-read bypass.
- Per-register busy scoreboard: set when an instruction issues with that destination, cleared on writeback. The pipelined CPU uses it for hazard detection.
- Sits between decode/issue (reads, issue) and writeback (writes).

---
 rtl/regf_mp.sv | 161 ++++++++++++++++
 tb/tb_regf_mp.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regf_mp.sv
// regf_mp: parametrised multi-port register file with two write ports,
// optional hardwired-zero register 0, optional write-to-read bypass and a
// per-register busy scoreboard used by the pipeline for hazard detection.
module regf_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NREAD    = 2,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREAD*ADDR_W-1:0]   raddr,
   output logic [NREAD*DATA_W-1:0]   rdata,
   output logic [NREAD-1:0]          rbusy,
   input  logic                      we0,
   input  logic [ADDR_W-1:0]         waddr0,
   input  logic [DATA_W-1:0]         wdata0,
   input  logic                      we1,
   input  logic [ADDR_W-1:0]         waddr1,
   input  logic [DATA_W-1:0]         wdata1,
   input  logic                      iss_valid,
   input  logic [ADDR_W-1:0]         iss_rd,
   output logic [ADDR_W:0]           busy_cnt
);

   localparam int NREG = 2 ** ADDR_W;

   // Architectural state
   logic [DATA_W-1:0] r_regs [NREG];
   logic [NREG-1:0]   r_busy;
   logic [ADDR_W:0]   r_busy_cnt;

   // Qualified write/issue strobes and their per-register decodes
   logic              w_we0_ok;
   logic              w_we1_ok;
   logic              w_iss_ok;
   logic [NREG-1:0]   w_hit0;
   logic [NREG-1:0]   w_hit1;
   logic [NREG-1:0]   w_iss_hit;
   logic [NREG-1:0]   w_busy_nxt;
   logic [ADDR_W:0]   w_busy_cnt_nxt;

   // True when the address selects the hardwired-zero register
   function automatic logic is_zero(input logic [ADDR_W-1:0] a);
      return ZERO_REG && (a == '0);
   endfunction

   // Accept writes/issues only outside reset and never to the zero register;
   // gating with rst_n keeps the bypass path quiet while reset is asserted.
   always_comb begin
      w_we0_ok = rst_n && we0       && !is_zero(waddr0);
      w_we1_ok = rst_n && we1       && !is_zero(waddr1);
      w_iss_ok = rst_n && iss_valid && !is_zero(iss_rd);
   end

   // Decode writes and issue per register and build the next busy vector;
   // an issue in the same cycle as a writeback wins (new producer).
   // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
   always_comb begin
      w_hit0     = '0;
      w_hit1     = '0;
      w_iss_hit  = '0;
      w_busy_nxt = r_busy;
      for (int i = 0; i < NREG; i++) begin
         w_hit0[i]    = w_we0_ok && (waddr0 == ADDR_W'(i));
         w_hit1[i]    = w_we1_ok && (waddr1 == ADDR_W'(i));
         w_iss_hit[i] = w_iss_ok && (iss_rd == ADDR_W'(i));
         if (w_iss_hit[i]) begin
            w_busy_nxt[i] = 1'b1;
         end else if (w_hit0[i] || w_hit1[i]) begin
            w_busy_nxt[i] = 1'b0;
         end
      end
   end

   // Population count of the next busy vector, registered with the bits
   // themselves so the count can never drift from them.
   always_comb begin
      w_busy_cnt_nxt = '0;
      for (int i = 0; i < NREG; i++) begin
         w_busy_cnt_nxt = w_busy_cnt_nxt + (ADDR_W+1)'(w_busy_nxt[i]);
      end
   end

   // Register storage; port 1 wins when both ports target the same register.
   // NOTE: the array is cleared by reset because nothing else may initialise storage; this costs a reset fan-out to every bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         for (int i = 0; i < NREG; i++) begin
            if (w_hit1[i]) begin
               r_regs[i] <= wdata1;
            end else if (w_hit0[i]) begin
               r_regs[i] <= wdata0;
            end
         end
      end
   end

   // Busy scoreboard bits and their registered count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy     <= '0;
         r_busy_cnt <= '0;
      end else begin
         r_busy     <= w_busy_nxt;
         r_busy_cnt <= w_busy_cnt_nxt;
      end
   end

   assign busy_cnt = r_busy_cnt;

   // Read ports: combinational data and busy flag per port
   for (genvar k = 0; k < NREAD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic [DATA_W-1:0] w_data;
      logic              w_busy;
      logic              w_wr_match;
      logic              w_iss_match;

      assign w_ra = raddr[k*ADDR_W +: ADDR_W];

      // Select stored value, overridden by same-cycle write data when
      // bypassing (port 1 last so it takes priority), zero register last.
      always_comb begin
         w_data = r_regs[w_ra];
         if (BYPASS && w_we0_ok && (waddr0 == w_ra)) begin
            w_data = wdata0;
         end
         if (BYPASS && w_we1_ok && (waddr1 == w_ra)) begin
            w_data = wdata1;
         end
         if (is_zero(w_ra)) begin
            w_data = '0;
         end
      end

      // Busy flag: a writeback this cycle releases the register early for
      // bypassing readers unless a new producer issues to it at once.
      always_comb begin
         w_wr_match  = (w_we0_ok && (waddr0 == w_ra)) || (w_we1_ok && (waddr1 == w_ra));
         w_iss_match = w_iss_ok && (iss_rd == w_ra);
         w_busy      = r_busy[w_ra];
         if (BYPASS && w_wr_match && !w_iss_match) begin
            w_busy = 1'b0;
         end
         if (is_zero(w_ra)) begin
            w_busy = 1'b0;
         end
      end

      assign rdata[k*DATA_W +: DATA_W] = w_data;
      assign rbusy[k]                  = w_busy;
   end

endmodule

// File: tb/tb_regf_mp.sv
// tb_regf_mp: directed scoreboard bench for regf_mp. One instance uses the
// default configuration (bypass on), a second shares its inputs with bypass
// off so same-cycle reads can be compared against the pre-edge value.
module tb_regf_mp;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NREAD  = 2;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [NREAD*ADDR_W-1:0] raddr;
   logic [NREAD*DATA_W-1:0] rdata;
   logic [NREAD*DATA_W-1:0] rdata_nb;
   logic [NREAD-1:0]        rbusy;
   logic [NREAD-1:0]        rbusy_nb;
   logic                    we0;
   logic [ADDR_W-1:0]       waddr0;
   logic [DATA_W-1:0]       wdata0;
   logic                    we1;
   logic [ADDR_W-1:0]       waddr1;
   logic [DATA_W-1:0]       wdata1;
   logic                    iss_valid;
   logic [ADDR_W-1:0]       iss_rd;
   logic [ADDR_W:0]         busy_cnt;
   logic [ADDR_W:0]         busy_cnt_nb;

   regf_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
      .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
      .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_cnt(busy_cnt)
   );

   regf_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_nb (
      .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb),
      .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
      .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_cnt(busy_cnt_nb)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [63:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_fail   = 0;

   // Queue an expected value at stimulus time
   task automatic expect_val(input string tag, input logic [63:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb_q.push_back(e);
   endtask

   // Pop the oldest expectation and compare it with the observed value
   task automatic check(input logic [63:0] obs);
      exp_t e;
      n_checks++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty: observed %h required <none>", obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e.val) n_pass++;
         else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
         end
      end
   endtask

   // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      we0 = 1'b0; waddr0 = '0; wdata0 = '0;
      we1 = 1'b0; waddr1 = '0; wdata1 = '0;
      iss_valid = 1'b0; iss_rd = '0;
   endtask

   task automatic set_raddr(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
      raddr = {a1, a0};
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      set_raddr(5'd5, 5'd6);
      repeat (2) tick();
      rst_n = 1'b1;
      #1;

      // Reset state
      expect_val("reset_rdata", 64'h0);
      expect_val("reset_rbusy", 64'h0);
      expect_val("reset_busy_cnt", 64'h0);
      check(rdata);
      check(rbusy);
      check(busy_cnt);

      // Two-port write r5/r6; bypass off still sees the old value
      we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
      we1 = 1'b1; waddr1 = 5'd6; wdata1 = 32'h12345678;
      #1;
      expect_val("wr_nobyp_old_r5", 64'h0);
      expect_val("wr_byp_r6", 64'h12345678);
      check(rdata_nb[31:0]);
      check(rdata[63:32]);
      tick();
      idle_inputs();
      #1;
      expect_val("rd_r5", 64'hDEADBEEF);
      expect_val("rd_r6", 64'h12345678);
      expect_val("rd_nb_r5_r6", {32'h12345678, 32'hDEADBEEF});
      check(rdata[31:0]);
      check(rdata[63:32]);
      check(rdata_nb);

      // Bypass of r3
      set_raddr(5'd3, 5'd6);
      we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hA5A5A5A5;
      #1;
      expect_val("byp_r3", 64'hA5A5A5A5);
      expect_val("nobyp_r3_old", 64'h0);
      check(rdata[31:0]);
      check(rdata_nb[31:0]);
      tick();
      idle_inputs();
      #1;
      expect_val("nobyp_r3_new", 64'hA5A5A5A5);
      check(rdata_nb[31:0]);

      // Write conflict on r7: port 1 wins, also on the bypass path
      set_raddr(5'd7, 5'd5);
      we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h00001111;
      we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h00002222;
      #1;
      expect_val("conflict_byp_r7", 64'h2222);
      expect_val("conflict_nobyp_r7_old", 64'h0);
      check(rdata[31:0]);
      check(rdata_nb[31:0]);
      tick();
      idle_inputs();
      #1;
      expect_val("conflict_r7", 64'h2222);
      expect_val("conflict_nb_r7", 64'h2222);
      check(rdata[31:0]);
      check(rdata_nb[31:0]);

      // Zero register: write and issue to r0 are dropped
      set_raddr(5'd0, 5'd5);
      we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
      iss_valid = 1'b1; iss_rd = 5'd0;
      #1;
      expect_val("zero_byp_rdata", 64'h0);
      expect_val("zero_rbusy", 64'h0);
      check(rdata[31:0]);
      check(rbusy[0]);
      tick();
      idle_inputs();
      #1;
      expect_val("zero_rdata", 64'h0);
      expect_val("zero_busy_cnt", 64'h0);
      check(rdata[31:0]);
      check(busy_cnt);

      // Scoreboard: issue r4 then r9
      set_raddr(5'd4, 5'd9);
      iss_valid = 1'b1; iss_rd = 5'd4;
      tick();
      expect_val("sb_cnt_1", 64'd1);
      expect_val("sb_rbusy_r4", 64'b01);
      check(busy_cnt);
      check(rbusy & 2'b01);
      iss_rd = 5'd9;
      tick();
      idle_inputs();
      #1;
      expect_val("sb_cnt_2", 64'd2);
      expect_val("sb_rbusy_r4_r9", 64'b11);
      check(busy_cnt);
      check(rbusy);

      // Writeback r4: bypass view releases it at once, non-bypass does not
      we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h00000044;
      #1;
      expect_val("wb_byp_rbusy", 64'b10);
      expect_val("wb_nobyp_rbusy", 64'b11);
      check(rbusy);
      check(rbusy_nb);
      tick();
      idle_inputs();
      #1;
      expect_val("wb_cnt_1", 64'd1);
      expect_val("wb_rbusy_after", 64'b10);
      expect_val("wb_rdata_r4", 64'h44);
      check(busy_cnt);
      check(rbusy);
      check(rdata[31:0]);

      // Issue and writeback to r9 together: stays busy
      we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h00000099;
      iss_valid = 1'b1; iss_rd = 5'd9;
      #1;
      expect_val("iss_wb_rbusy_same", 64'b1);
      expect_val("iss_wb_rdata_byp", 64'h99);
      check(rbusy[1]);
      check(rdata[63:32]);
      tick();
      idle_inputs();
      #1;
      expect_val("iss_wb_cnt", 64'd1);
      expect_val("iss_wb_rbusy_after", 64'b1);
      check(busy_cnt);
      check(rbusy[1]);

      // Saturation: issue every register 1..31
      for (int i = 1; i < 32; i++) begin
         iss_valid = 1'b1;
         iss_rd    = ADDR_W'(i);
         tick();
      end
      idle_inputs();
      set_raddr(5'd31, 5'd1);
      #1;
      expect_val("sat_cnt", 64'd31);
      expect_val("sat_cnt_nb", 64'd31);
      expect_val("sat_rbusy", 64'b11);
      check(busy_cnt);
      check(busy_cnt_nb);
      check(rbusy);
      iss_valid = 1'b1; iss_rd = 5'd1;
      tick();
      idle_inputs();
      #1;
      expect_val("reissue_cnt", 64'd31);
      check(busy_cnt);

      // Asynchronous reset mid-cycle with a write and an issue pending
      set_raddr(5'd5, 5'd6);
      we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h00000055;
      iss_valid = 1'b1; iss_rd = 5'd2;
      #2;
      rst_n = 1'b0;
      #1;
      expect_val("async_rst_rdata", 64'h0);
      expect_val("async_rst_rbusy", 64'h0);
      expect_val("async_rst_cnt", 64'h0);
      expect_val("async_rst_rdata_nb", 64'h0);
      check(rdata);
      check(rbusy);
      check(busy_cnt);
      check(rdata_nb);
      tick();
      idle_inputs();
      rst_n = 1'b1;
      tick();
      expect_val("post_rst_r5", 64'h0);
      expect_val("post_rst_cnt", 64'h0);
      check(rdata[31:0]);
      check(busy_cnt);

      if (sb_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $error("FAIL scoreboard_leftover: observed %0d entries required 0", sb_q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
